// File: rtl/acc_seq_ctrl_if.sv
// Sample/result bundle for acc_seq_ctrl.
// master drives start/len/in_valid/flag/sub/a; slave returns b/cnt/busy/done/ovf.
interface acc_seq_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 4
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              flag;
  logic              sub;
  logic [DATA_W-1:0] a;
  logic [ACC_W-1:0]  b;
  logic [CNT_W-1:0]  cnt;
  logic              busy;
  logic              done;
  logic              ovf;

  modport master (
    output start, len, in_valid, flag, sub, a,
    input  b, cnt, busy, done, ovf
  );

  modport slave (
    input  start, len, in_valid, flag, sub, a,
    output b, cnt, busy, done, ovf
  );
endinterface

// File: rtl/acc_seq_ctrl.sv
// Length-controlled add/sub accumulator with sticky overflow and done pulse.
// Ports: clk, rst_n (async low), bus (slave: start,len,in_valid,flag,sub,a -> b,cnt,busy,done,ovf).
// Macro ACC_SAT_EN: saturate b on overflow instead of wrapping.
module acc_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 12,
  parameter int CNT_W  = 4
) (
  input logic           clk,
  input logic           rst_n,
  acc_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;

  logic             acc_ok;
  logic [ACC_W:0]   a_ext;
  logic [ACC_W:0]   b_ext;
  logic [ACC_W:0]   sum;
  logic             of;
  logic [ACC_W-1:0] b_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             last;

  assign acc_ok = (state == RUN) && bus.in_valid
                  && !bus.flag && !bus.start;

  assign a_ext = {{(ACC_W+1-DATA_W){bus.a[DATA_W-1]}}, bus.a};
  assign b_ext = {b_q[ACC_W-1], b_q};
  assign sum   = bus.sub ? (b_ext - a_ext) : (b_ext + a_ext);

  // one guard bit: result left the ACC_W range when top two bits differ
  assign of = sum[ACC_W] ^ sum[ACC_W-1];

`ifdef ACC_SAT_EN
  localparam logic [ACC_W-1:0] B_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] B_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  assign b_nxt = !of       ? sum[ACC_W-1:0] :
                 sum[ACC_W] ? B_MIN : B_MAX;
`else
  assign b_nxt = sum[ACC_W-1:0];
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign last    = (len_q != '0) && (cnt_inc == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      b_q    <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.start) begin
      state  <= RUN;
      b_q    <= '0;
      cnt_q  <= '0;
      len_q  <= bus.len;
      busy_q <= 1'b1;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: ;
        RUN: begin
          if (acc_ok) begin
            b_q   <= b_nxt;
            cnt_q <= cnt_inc;
            if (of) ovf_q <= 1'b1;
            if (last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.b    = b_q;
  assign bus.cnt  = cnt_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed self-checking bench for acc_seq_ctrl.
// Checks packed {b,cnt,busy,done,ovf} against hand-computed values.
module tb_acc_seq_ctrl;

  logic clk;
  logic rst_n;
  int   errs;
  int   chks;

  acc_seq_ctrl_if #(.DATA_W(8), .ACC_W(12), .CNT_W(4)) bus ();

  acc_seq_ctrl #(.DATA_W(8), .ACC_W(12), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] obs();
    return {bus.b, bus.cnt, bus.busy, bus.done, bus.ovf};
  endfunction

  task automatic drive(input logic st, input logic [3:0] l,
                       input logic v, input logic f,
                       input logic s, input logic [7:0] d);
    bus.start    = st;
    bus.len      = l;
    bus.in_valid = v;
    bus.flag     = f;
    bus.sub      = s;
    bus.a        = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [18:0] exp;
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    drive(1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 8'd5);
    cyc();
    exp = {12'd5, 4'd1, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL pre_reset_run: got %h want %h", obs(), exp);
    end
    #3 rst_n = 1'b0;
    #1;
    exp = '0;
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL async_reset: got %h want %h", obs(), exp);
    end
    #2 rst_n = 1'b1;
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd33);
    cyc();
    cyc();
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL idle_ignore: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_basic();
    logic [18:0] exp;
    drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    exp = {12'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL basic_start: got %h want %h", obs(), exp);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd10);
    cyc();
    bus.a = 8'd20;
    cyc();
    bus.a = 8'd30;
    cyc();
    exp = {12'd60, 4'd3, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL basic_mid: got %h want %h", obs(), exp);
    end
    bus.a = 8'd40;
    cyc();
    exp = {12'd100, 4'd4, 1'b0, 1'b1, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL basic_done: got %h want %h", obs(), exp);
    end
    bus.a = 8'd50;
    cyc();
    exp = {12'd100, 4'd4, 1'b0, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL basic_hold: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_hold_sub();
    logic [18:0] exp;
    drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    drive(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 8'd5);
    cyc();
    cyc();
    exp = {12'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL hold_flag: got %h want %h", obs(), exp);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd5);
    cyc();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 8'hFD);
    cyc();
    exp = {12'd8, 4'd2, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL sub_neg: got %h want %h", obs(), exp);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd2);
    cyc();
    exp = {12'd10, 4'd3, 1'b0, 1'b1, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL sub_done: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_overflow();
    logic [18:0] exp;
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd127);
    for (int i = 0; i < 16; i++) cyc();
    exp = {12'd2032, 4'd0, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL ovf_edge: got %h want %h", obs(), exp);
    end
    cyc();
`ifdef ACC_SAT_EN
    exp = {12'd2047, 4'd1, 1'b1, 1'b0, 1'b1};
`else
    exp = {12'(-1937), 4'd1, 1'b1, 1'b0, 1'b1};
`endif
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL ovf_pos: got %h want %h", obs(), exp);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 8'd100);
    cyc();
`ifdef ACC_SAT_EN
    exp = {12'd1947, 4'd2, 1'b1, 1'b0, 1'b1};
`else
    exp = {12'(-2037), 4'd2, 1'b1, 1'b0, 1'b1};
`endif
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL ovf_sticky: got %h want %h", obs(), exp);
    end
    drive(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'h80);
    for (int i = 0; i < 17; i++) cyc();
`ifdef ACC_SAT_EN
    exp = {12'(-2048), 4'd1, 1'b1, 1'b0, 1'b1};
`else
    exp = {12'd1920, 4'd1, 1'b1, 1'b0, 1'b1};
`endif
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL ovf_neg: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_restart();
    logic [18:0] exp;
    drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd9);
    cyc();
    cyc();
    exp = {12'd18, 4'd2, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL restart_pre: got %h want %h", obs(), exp);
    end
    drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 8'd50);
    cyc();
    exp = {12'd0, 4'd0, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL restart_clr: got %h want %h", obs(), exp);
    end
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd1);
    for (int i = 0; i < 4; i++) cyc();
    exp = {12'd4, 4'd4, 1'b1, 1'b0, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL restart_mid: got %h want %h", obs(), exp);
    end
    cyc();
    exp = {12'd5, 4'd5, 1'b0, 1'b1, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL restart_done: got %h want %h", obs(), exp);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [18:0] exp;
    drive(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'd4);
    cyc();
    cyc();
    #3 rst_n = 1'b0;
    #1;
    exp = '0;
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL midrun_rst: got %h want %h", obs(), exp);
    end
    cyc();
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL midrun_nodone: got %h want %h", obs(), exp);
    end
    #4 rst_n = 1'b1;
    drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 8'd0);
    cyc();
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 8'hF9);
    cyc();
    exp = {12'(-7), 4'd1, 1'b0, 1'b1, 1'b0};
    chks++;
    if (obs() !== exp) begin
      errs++;
      $display("FAIL post_rst_run: got %h want %h", obs(), exp);
    end
  endtask

  initial begin
    errs  = 0;
    chks  = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    #12 rst_n = 1'b1;
    cyc();
    test_reset();
    test_basic();
    test_hold_sub();
    test_overflow();
    test_restart();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
